// File: rtl/pixel_frame_collector.sv
// pixel_frame_collector
// Tags each incoming pipeline pixel with its (row, col) position and buffers
// it in a small FIFO so a back-pressuring sink can drain it. Frame markers
// (sof/eol/eof) are derived from the stored coordinates on the read side.
// Pixels arriving while the FIFO is full and not draining are dropped, and a
// sticky overflow flag is raised. Dropped pixels still advance the position
// counters, so the frame geometry stays aligned.

module pixel_frame_collector #(
    parameter int FRAME_W    = 510,
    parameter int FRAME_H    = 510,
    parameter int FIFO_DEPTH = 16,
    localparam int COL_W     = (FRAME_W > 1) ? $clog2(FRAME_W) : 1,
    localparam int ROW_W     = (FRAME_H > 1) ? $clog2(FRAME_H) : 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [7:0]       pixel_in,
    input  logic             pixel_in_valid,
    output logic [7:0]       pixel_out,
    output logic             pixel_out_valid,
    input  logic             pixel_out_ready,
    output logic [COL_W-1:0] pixel_out_col,
    output logic [ROW_W-1:0] pixel_out_row,
    output logic             pixel_out_sof,
    output logic             pixel_out_eol,
    output logic             pixel_out_eof,
    output logic             frame_done,
    output logic             overflow,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    typedef struct packed {
        logic [7:0]       pix;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } entry_t;

    entry_t           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [0:0]       r_state;
    logic             r_overflow;
    logic             r_frame_done;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_frame_end;
    entry_t           w_head;
    logic             w_head_sof;
    logic             w_head_eol;
    logic             w_head_eof;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == LVL_W'(FIFO_DEPTH));
    // A pop frees a slot on the same edge, so a full FIFO can still accept.
    assign w_pop       = !w_empty && pixel_out_ready;
    assign w_push      = pixel_in_valid && (!w_full || w_pop);

    assign w_last_col  = (r_col == COL_W'(FRAME_W - 1));
    assign w_last_row  = (r_row == ROW_W'(FRAME_H - 1));
    assign w_frame_end = w_last_col && w_last_row;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_sof  = (w_head.row == '0) && (w_head.col == '0);
    assign w_head_eol  = (w_head.col == COL_W'(FRAME_W - 1));
    assign w_head_eof  = w_head_eol && (w_head.row == ROW_W'(FRAME_H - 1));

    // Storage array: written on push only.
    // NOTE: the data array carries no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (rstN && w_push) begin
            r_mem[r_wr_ptr] <= '{pix: pixel_in, row: r_row, col: r_col};
        end
    end

    // FIFO pointers and exact occupancy count.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Write-side position counters; advance on every valid, stored or dropped.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pixel_in_valid) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Frame receive FSM: RECV while a frame is partially received.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= ST_IDLE;
        end else if (pixel_in_valid) begin
            case (r_state)
                ST_IDLE: r_state <= w_frame_end ? ST_IDLE : ST_RECV;
                ST_RECV: r_state <= w_frame_end ? ST_IDLE : ST_RECV;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky drop flag and end-of-frame pulse following the eof handshake.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (pixel_in_valid && !w_push) r_overflow <= 1'b1;
            r_frame_done <= w_pop && w_head_eof;
        end
    end

    // Outputs are forced to zero while empty so nothing stale leaks out.
    assign pixel_out_valid = !w_empty;
    assign pixel_out       = w_empty ? 8'h00 : w_head.pix;
    assign pixel_out_col   = w_empty ? '0 : w_head.col;
    assign pixel_out_row   = w_empty ? '0 : w_head.row;
    assign pixel_out_sof   = !w_empty && w_head_sof;
    assign pixel_out_eol   = !w_empty && w_head_eol;
    assign pixel_out_eof   = !w_empty && w_head_eof;
    assign frame_done      = r_frame_done;
    assign overflow        = r_overflow;
    assign fifo_level      = r_count;

endmodule

// File: tb/tb_pixel_frame_collector.sv
// Scoreboard bench for pixel_frame_collector on a 4x3 frame with a 4-deep
// FIFO. Stimulus pushes expected beats into a queue; a negedge monitor pops
// and compares on every output handshake and tracks frame_done pulses.

module tb_pixel_frame_collector;

    localparam int FW = 4;
    localparam int FH = 3;
    localparam int FD = 4;

    typedef struct packed {
        logic [7:0] pix;
        logic [1:0] row;
        logic [1:0] col;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [7:0] pixel_in = 8'h00;
    logic       pixel_in_valid = 1'b0;
    logic [7:0] pixel_out;
    logic       pixel_out_valid;
    logic       pixel_out_ready = 1'b0;
    logic [1:0] pixel_out_col;
    logic [1:0] pixel_out_row;
    logic       pixel_out_sof;
    logic       pixel_out_eol;
    logic       pixel_out_eof;
    logic       frame_done;
    logic       overflow;
    logic [2:0] fifo_level;

    pixel_frame_collector #(
        .FRAME_W   (FW),
        .FRAME_H   (FH),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk            (clk),
        .rstN           (rstN),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .pixel_out      (pixel_out),
        .pixel_out_valid(pixel_out_valid),
        .pixel_out_ready(pixel_out_ready),
        .pixel_out_col  (pixel_out_col),
        .pixel_out_row  (pixel_out_row),
        .pixel_out_sof  (pixel_out_sof),
        .pixel_out_eol  (pixel_out_eol),
        .pixel_out_eof  (pixel_out_eof),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t exp_q[$];
    logic  mon_en  = 1'b0;
    logic  exp_fd  = 1'b0;
    int    fd_seen = 0;

    // Bench-side reference state for the write side and occupancy.
    int    m_cnt = 0;
    int    m_row = 0;
    int    m_col = 0;
    logic  m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; updates the reference and the scoreboard.
    task automatic cycle(input logic v, input logic [7:0] p, input logic rdy);
        logic  pop;
        logic  push;
        beat_t b;
        pixel_in_valid  = v;
        pixel_in        = p;
        pixel_out_ready = rdy;
        pop  = rdy && (m_cnt > 0);
        push = v && ((m_cnt < FD) || pop);
        if (push) begin
            b.pix = p;
            b.row = 2'(m_row);
            b.col = 2'(m_col);
            b.sof = (m_row == 0) && (m_col == 0);
            b.eol = (m_col == FW - 1);
            b.eof = (m_col == FW - 1) && (m_row == FH - 1);
            exp_q.push_back(b);
        end
        if (v && !push) m_ovf = 1'b1;
        if (v) begin
            if (m_col == FW - 1) begin
                m_col = 0;
                m_row = (m_row == FH - 1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end
        m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles, input logic v);
        rstN            = 1'b0;
        pixel_in_valid  = v;
        pixel_in        = 8'hEE;
        pixel_out_ready = 1'b1;
        exp_q.delete();
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, pixel_out_valid}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        rstN           = 1'b1;
        pixel_in_valid = 1'b0;
        m_cnt = 0;
        m_row = 0;
        m_col = 0;
        m_ovf = 1'b0;
    endtask

    // Drain with a cycle budget, then one idle cycle so frame_done is seen.
    task automatic drain(input string name);
        for (int i = 0; i < 32 && pixel_out_valid; i++) cycle(1'b0, 8'h00, 1'b1);
        check({name, "_drained"}, {31'd0, pixel_out_valid}, 32'd0);
        check({name, "_sb_empty"}, exp_q.size(), 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
    endtask

    // Monitor: compares each accepted beat and the frame_done pulse.
    always @(negedge clk) begin
        beat_t got;
        beat_t b;
        logic  next_fd;
        if (mon_en) begin
            check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
            if (frame_done) fd_seen++;
            next_fd = 1'b0;
            if (rstN && pixel_out_valid && pixel_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {31'd0, pixel_out_valid}, 32'd0);
                end else begin
                    b   = exp_q.pop_front();
                    got = '{pix: pixel_out, row: pixel_out_row, col: pixel_out_col,
                            sof: pixel_out_sof, eol: pixel_out_eol, eof: pixel_out_eof};
                    check("beat", 32'(got), 32'(b));
                    next_fd = b.eof;
                end
            end
            exp_fd = next_fd;
        end
    end

    initial begin
        int fd0;
        logic rdy;

        // Reset with a valid pixel held on the input: it must be ignored.
        do_reset(2, 1'b1);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_pixel", {24'd0, pixel_out}, 32'd0);
        mon_en = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        check("post_rst_level", {29'd0, fifo_level}, 32'd0);

        // One full frame streamed with the sink always ready.
        fd0 = fd_seen;
        cycle(1'b1, 8'h00, 1'b1);
        check("latency_valid", {31'd0, pixel_out_valid}, 32'd1);
        check("latency_pixel", {24'd0, pixel_out}, 32'h00);
        check("latency_sof", {31'd0, pixel_out_sof}, 32'd1);
        for (int i = 1; i < 12; i++) cycle(1'b1, 8'(i), 1'b1);
        drain("frame1");
        check("frame1_done_pulses", fd_seen - fd0, 32'd1);
        check("frame1_overflow", {31'd0, overflow}, 32'd0);

        // Sink stalled: four fit, the fifth is dropped.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
        check("full_level", {29'd0, fifo_level}, 32'd4);
        check("full_overflow", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        check("after_drain_level", {29'd0, fifo_level}, 32'd0);
        cycle(1'b1, 8'hA5, 1'b1);
        check("a5_pixel", {24'd0, pixel_out}, 32'hA5);
        check("a5_row", {30'd0, pixel_out_row}, 32'd1);
        check("a5_col", {30'd0, pixel_out_col}, 32'd1);
        drain("ovf");
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full FIFO with a simultaneous pop and push: nothing is lost.
        do_reset(1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hB0 + 8'(i), 1'b0);
        check("b_full_level", {29'd0, fifo_level}, 32'd4);
        cycle(1'b1, 8'hB4, 1'b1);
        check("b_pushpop_level", {29'd0, fifo_level}, 32'd4);
        check("b_pushpop_overflow", {31'd0, overflow}, 32'd0);

        // Stall: head beat B1 at (0,1) must hold for three cycles.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            check("hold_valid", {31'd0, pixel_out_valid}, 32'd1);
            check("hold_pixel", {24'd0, pixel_out}, 32'hB1);
            check("hold_tag", {28'd0, pixel_out_row, pixel_out_col}, 32'h1);
            check("hold_flags", {29'd0, pixel_out_sof, pixel_out_eol, pixel_out_eof}, 32'd0);
        end
        drain("hold");

        // Two frames back to back with a randomly stalling sink.
        do_reset(1, 1'b0);
        fd0 = fd_seen;
        for (int i = 0; i < 24; i++) begin
            rdy = (m_cnt == FD) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle(1'b1, 8'h40 + 8'(i), rdy);
            check("rand_level", {29'd0, fifo_level}, 32'(m_cnt));
        end
        drain("two_frames");
        check("two_frames_done_pulses", fd_seen - fd0, 32'd2);
        check("two_frames_overflow", {31'd0, overflow}, 32'd0);

        // Reset mid-frame discards buffered pixels and restarts tagging.
        do_reset(1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
        check("mid_level", {29'd0, fifo_level}, 32'd4);
        do_reset(1, 1'b0);
        check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        cycle(1'b1, 8'hD0, 1'b1);
        check("restart_pixel", {24'd0, pixel_out}, 32'hD0);
        check("restart_tag", {28'd0, pixel_out_row, pixel_out_col}, 32'd0);
        check("restart_sof", {31'd0, pixel_out_sof}, 32'd1);
        drain("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
